// File: rtl/vga_timing_pkg.sv
// Default 640x480 raster timing (25 MHz pixel from 100 MHz clk) and the shared coordinate type.
package vga_timing_pkg;

    localparam int CLK_DIV     = 4;

    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 784;

    localparam int V_TOTAL     = 521;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 31;
    localparam int V_VIS_END   = 511;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: div counter 0..CLK_DIV-1, registered pix_en high the cycle after it reaches CLK_DIV-1.
module vga_pix_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en_o
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_pix_div: CLK_DIV must be in 2..16");
    end

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          pix_en_q;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= (div_q == DIV_LAST);
        end
    end

    assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, syncs, visible flag and line/frame strobes; all outputs registered from next-state counters.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN (otherwise frame_cnt is tied to zero).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = vga_timing_pkg::CLK_DIV,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_VIS_START = vga_timing_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_timing_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_VIS_START = vga_timing_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_timing_pkg::V_VIS_END
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [9:0]  hc,
    output logic [9:0]  vc,
    output logic        hsync,
    output logic        vsync,
    output logic        videoen,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    if (!(H_SYNC < H_VIS_START && H_VIS_START < H_VIS_END && H_VIS_END <= H_TOTAL && H_TOTAL <= 1024) ||
        !(V_SYNC < V_VIS_START && V_VIS_START < V_VIS_END && V_VIS_END <= V_TOTAL && V_TOTAL <= 1024))
    begin : g_bad_params
        $error("vga_timing_gen: timing parameters out of order");
    end

    // 11-bit bounds so a VIS_END of 1024 still compares correctly against a 10-bit counter
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [10:0] H_VS_W    = 11'(H_VIS_START);
    localparam logic [10:0] H_VE_W    = 11'(H_VIS_END);
    localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
    localparam logic [10:0] V_VS_W    = 11'(V_VIS_START);
    localparam logic [10:0] V_VE_W    = 11'(V_VIS_END);
    localparam coord_t      H_LAST    = 10'(H_TOTAL - 1);
    localparam coord_t      V_LAST    = 10'(V_TOTAL - 1);

    logic   pix_en_w;
    coord_t hc_q, hc_d;
    coord_t vc_q, vc_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   videoen_q, videoen_d;
    logic   line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;
    logic   h_wrap, v_wrap;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .rst      (rst),
        .pix_en_o (pix_en_w)
    );

    always_comb begin
        h_wrap        = (hc_q == H_LAST);
        v_wrap        = (vc_q == V_LAST);
        hc_d          = hc_q;
        vc_d          = vc_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_en_w) begin
            if (h_wrap) begin
                hc_d          = '0;
                vc_d          = v_wrap ? '0 : vc_q + 10'd1;
                line_start_d  = 1'b1;
                frame_start_d = v_wrap;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
        hsync_d   = ({1'b0, hc_d} >= H_SYNC_W);
        vsync_d   = ({1'b0, vc_d} >= V_SYNC_W);
        videoen_d = ({1'b0, hc_d} >= H_VS_W) && ({1'b0, hc_d} < H_VE_W) &&
                    ({1'b0, vc_d} >= V_VS_W) && ({1'b0, vc_d} < V_VE_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q          <= '0;
            vc_q          <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            videoen_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            videoen_q     <= videoen_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

    assign pix_en      = pix_en_w;
    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign videoen     = videoen_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken 16x10 raster so whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int CD  = 4;
    localparam int HT  = 16;
    localparam int HS  = 2;
    localparam int HVS = 4;
    localparam int HVE = 14;
    localparam int VT  = 10;
    localparam int VS  = 2;
    localparam int VVS = 3;
    localparam int VVE = 8;
    localparam int FRAME = HT * VT;
`ifdef VGA_FRAME_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en;
    logic [9:0]  hc, vc;
    logic        hsync, vsync, videoen, line_start, frame_start;
    logic [15:0] frame_cnt;

    vga_timing_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_VIS_START(HVS), .H_VIS_END(HVE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_VIS_START(VVS), .V_VIS_END(VVE)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hc(hc), .vc(vc),
        .hsync(hsync), .vsync(vsync), .videoen(videoen),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic        hs, vs, ve, ls, fs;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;
    bit   upd    = 1'b0;
    int   gap    = 0;
    int   nup    = 0;
    int   ve_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected raster state after the k-th pixel enable, derived from the pixel index alone
    task automatic push_pixels(input int n);
        exp_t e;
        int p, h, v;
        for (int k = 1; k <= n; k++) begin
            p    = k % FRAME;
            h    = p % HT;
            v    = p / HT;
            e.hc = 10'(h);
            e.vc = 10'(v);
            e.hs = (h >= HS);
            e.vs = (v >= VS);
            e.ve = (h >= HVS) && (h < HVE) && (v >= VVS) && (v < VVE);
            e.ls = (h == 0);
            e.fs = (p == 0);
            e.fc = FC_EN ? 16'(k / FRAME) : 16'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pix_en"}, int'(pix_en), 0);
        chk({tag, "_hc"}, int'(hc), 0);
        chk({tag, "_vc"}, int'(vc), 0);
        chk({tag, "_hsync"}, int'(hsync), 0);
        chk({tag, "_vsync"}, int'(vsync), 0);
        chk({tag, "_videoen"}, int'(videoen), 0);
        chk({tag, "_line_start"}, int'(line_start), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    endtask

    task automatic release_and_first_pix(input string tag);
        int edge_n;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        edge_n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (pix_en) begin
                edge_n = i;
                break;
            end
        end
        chk({tag, "_first_pix_en_edge"}, edge_n, CD);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        chk({tag, "_scoreboard_left"}, exp_q.size(), 0);
    endtask

    // pix_en value seen just before each edge, i.e. whether counters advanced on it
    always @(posedge clk) upd <= pix_en;

    always @(negedge clk) begin
        exp_t e;
        if (rst || !mon_en) begin
            gap    = 0;
            nup    = 0;
            ve_cnt = 0;
        end else begin
            gap++;
            if (upd) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("hc", int'(hc), int'(e.hc));
                    chk("vc", int'(vc), int'(e.vc));
                    chk("hsync", int'(hsync), int'(e.hs));
                    chk("vsync", int'(vsync), int'(e.vs));
                    chk("videoen", int'(videoen), int'(e.ve));
                    chk("line_start", int'(line_start), int'(e.ls));
                    chk("frame_start", int'(frame_start), int'(e.fs));
                    chk("frame_cnt", int'(frame_cnt), int'(e.fc));
                    if (nup > 0) chk("pix_period", gap, CD);
                    nup++;
                    gap = 0;
                    if (nup <= FRAME && videoen) ve_cnt++;
                end
            end else begin
                chk("line_start_idle", int'(line_start), 0);
                chk("frame_start_idle", int'(frame_start), 0);
            end
        end
    end

    initial begin
        int waited;
        bit found;
        #3;
        check_reset_vals("por");

        push_pixels(3 * FRAME + 20);
        release_and_first_pix("run1");
        drain("run1", (3 * FRAME + 40) * CD);
        chk("videoen_per_frame", ve_cnt, (HVE - HVS) * (VVE - VVS));

        // Async reset in mid-frame, deliberately away from any clock edge
        mon_en = 1'b0;
        found  = 1'b0;
        for (waited = 0; waited < 2 * FRAME * CD && !found; waited++) begin
            @(negedge clk);
            if (hc == 10'd9 && vc == 10'd5) found = 1'b1;
        end
        chk("mid_frame_point_reached", int'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        exp_q.delete();
        push_pixels(FRAME + 20);
        #7;
        release_and_first_pix("run2");
        drain("run2", (FRAME + 40) * CD);

`ifdef VGA_FRAME_COUNT_EN
        mon_en = 1'b0;
        @(negedge clk);
        dut.frame_cnt_q = 16'hFFFE;
        for (int f = 1; f <= 2; f++) begin
            found = 1'b0;
            for (waited = 0; waited < 2 * FRAME * CD && !found; waited++) begin
                @(negedge clk);
                if (frame_start) found = 1'b1;
            end
            chk("frame_start_seen", int'(found), 1);
            chk("frame_cnt_wrap", int'(frame_cnt), (f == 1) ? 16'hFFFF : 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
